// File: rtl/spi_xfer_sequencer_if.sv
// Bundles the command, response and SPI-master signals of spi_xfer_sequencer.
//   cmd_*   : command stream in (valid/ready), target slave and byte to send
//   rsp_*   : response stream out (valid/ready), slave and byte received
//   start, slaveSelect, masterDataToSend, masterDataReceived : SPI master side
//   busy, err : status
// Modport slave is the sequencer's view; modport master is the user/bench view.
interface spi_xfer_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_sel;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_sel;
  logic [7:0] rsp_data;
  logic       start;
  logic [1:0] slaveSelect;
  logic [7:0] masterDataToSend;
  logic [7:0] masterDataReceived;
  logic       busy;
  logic       err;

  modport slave (
    input  cmd_valid, cmd_sel, cmd_data, rsp_ready, masterDataReceived,
    output cmd_ready, rsp_valid, rsp_sel, rsp_data, start, slaveSelect, masterDataToSend,
           busy, err
  );

  modport master (
    output cmd_valid, cmd_sel, cmd_data, rsp_ready, masterDataReceived,
    input  cmd_ready, rsp_valid, rsp_sel, rsp_data, start, slaveSelect, masterDataToSend,
           busy, err
  );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// Sequences byte transfers to an external SPI master. Commands (slave, byte) are queued in
// a DEPTH-entry FIFO; one at a time they are launched with a start pulse, the received byte
// is captured XFER_CYCLES cycles later and queued with its slave number in a DEPTH-entry
// response FIFO. Commands addressed to slave 3 are dropped and flag a sticky error.
// Ports:
//   clk   : clock, all state on posedge
//   reset : asynchronous, active-high
//   bus   : spi_xfer_sequencer_if.slave (command/response streams, SPI master side, status)
// Parameters: DEPTH power of two 2..16; XFER_CYCLES >= 1; GAP_CYCLES >= 1.
module spi_xfer_sequencer #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned XFER_CYCLES = 9,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input logic                 clk,
  input logic                 reset,
  spi_xfer_sequencer_if.slave bus
);

  localparam int unsigned     PtrW    = $clog2(DEPTH);
  localparam int unsigned     OccW    = $clog2(DEPTH) + 1;
  localparam logic [OccW-1:0] OccFull = OccW'(DEPTH);
  localparam int unsigned     CntMax  = (XFER_CYCLES > GAP_CYCLES) ? XFER_CYCLES : GAP_CYCLES;
  localparam int unsigned     CntW    = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] XferLoad = CntW'(XFER_CYCLES - 1);
  localparam logic [CntW-1:0] GapLoad  = CntW'(GAP_CYCLES - 1);
  localparam logic [1:0]      SelNone  = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStart,
    StXfer,
    StCapture,
    StGap
  } state_e;

  state_e r_state;
  state_e w_state_d;

  // Command FIFO
  logic [1:0]      r_cmd_sel  [DEPTH];
  logic [7:0]      r_cmd_data [DEPTH];
  logic [PtrW-1:0] r_cmd_wptr;
  logic [PtrW-1:0] r_cmd_rptr;
  logic [OccW-1:0] r_cmd_cnt;
  logic            w_cmd_ready;
  logic            w_cmd_empty;
  logic            w_cmd_push;
  logic            w_cmd_pop;
  logic [1:0]      w_head_sel;
  logic [7:0]      w_head_data;

  // Response FIFO
  logic [1:0]      r_rsp_sel  [DEPTH];
  logic [7:0]      r_rsp_data [DEPTH];
  logic [PtrW-1:0] r_rsp_wptr;
  logic [PtrW-1:0] r_rsp_rptr;
  logic [OccW-1:0] r_rsp_cnt;
  logic            w_rsp_valid;
  logic            w_rsp_full;
  logic            w_rsp_push;
  logic            w_rsp_pop;

  // Transfer registers and outputs
  logic [1:0]      r_sel;
  logic [7:0]      r_data;
  logic [CntW-1:0] r_cnt;
  logic            r_err;
  logic            w_start;
  logic [1:0]      w_slave_select;
  logic            w_busy;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  assign w_cmd_ready = (r_cmd_cnt != OccFull);
  assign w_cmd_empty = (r_cmd_cnt == '0);
  assign w_cmd_push  = bus.cmd_valid && w_cmd_ready;
  assign w_head_sel  = r_cmd_sel[r_cmd_rptr];
  assign w_head_data = r_cmd_data[r_cmd_rptr];

  always_ff @(posedge clk) begin
    if (w_cmd_push) begin
      r_cmd_sel[r_cmd_wptr]  <= bus.cmd_sel;
      r_cmd_data[r_cmd_wptr] <= bus.cmd_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd_wptr <= '0;
      r_cmd_rptr <= '0;
      r_cmd_cnt  <= '0;
    end else begin
      if (w_cmd_push) r_cmd_wptr <= r_cmd_wptr + PtrW'(1);
      if (w_cmd_pop)  r_cmd_rptr <= r_cmd_rptr + PtrW'(1);
      r_cmd_cnt <= r_cmd_cnt + OccW'(w_cmd_push) - OccW'(w_cmd_pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  assign w_rsp_valid = (r_rsp_cnt != '0);
  assign w_rsp_full  = (r_rsp_cnt == OccFull);
  assign w_rsp_pop   = w_rsp_valid && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (w_rsp_push) begin
      r_rsp_sel[r_rsp_wptr]  <= r_sel;
      r_rsp_data[r_rsp_wptr] <= bus.masterDataReceived;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_wptr <= '0;
      r_rsp_rptr <= '0;
      r_rsp_cnt  <= '0;
    end else begin
      if (w_rsp_push) r_rsp_wptr <= r_rsp_wptr + PtrW'(1);
      if (w_rsp_pop)  r_rsp_rptr <= r_rsp_rptr + PtrW'(1);
      r_rsp_cnt <= r_rsp_cnt + OccW'(w_rsp_push) - OccW'(w_rsp_pop);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and command pop
  // ---------------------------------------------------------------------------
  // A launch is only taken when the response FIFO has room, so CAPTURE never has to
  // stall. A slave-3 command is popped and dropped without leaving IDLE.
  always_comb begin
    w_state_d = r_state;
    w_cmd_pop = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_cmd_empty && !w_rsp_full) begin
          w_cmd_pop = 1'b1;
          if (w_head_sel != SelNone) w_state_d = StSetup;
        end
      end
      StSetup:   w_state_d = StStart;
      StStart:   w_state_d = StXfer;
      StXfer:    if (r_cnt == '0) w_state_d = StCapture;
      StCapture: w_state_d = StGap;
      StGap:     if (r_cnt == '0) w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_start        = 1'b0;
    w_slave_select = SelNone;
    w_busy         = 1'b1;
    w_rsp_push     = 1'b0;
    unique case (r_state)
      StIdle:    w_busy = 1'b0;
      StSetup:   w_slave_select = r_sel;
      StStart: begin
        w_slave_select = r_sel;
        w_start        = 1'b1;
      end
      StXfer:    w_slave_select = r_sel;
      StCapture: w_rsp_push = 1'b1;
      default:   ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transfer registers and cycle counter
  // ---------------------------------------------------------------------------
  // r_data is only loaded by a real launch, so masterDataToSend holds its last value
  // across idle periods and dropped slave-3 commands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel  <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else if (w_cmd_pop) begin
      if (w_head_sel == SelNone) begin
        r_err <= 1'b1;
      end else begin
        r_sel  <= w_head_sel;
        r_data <= w_head_data;
      end
    end
  end

  // One down-counter serves both XFER and GAP; it is loaded in the state before each.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        StStart:      r_cnt <= XferLoad;
        StCapture:    r_cnt <= GapLoad;
        StXfer, StGap: if (r_cnt != '0) r_cnt <= r_cnt - CntW'(1);
        default:      ;
      endcase
    end
  end

  assign bus.cmd_ready        = w_cmd_ready;
  assign bus.rsp_valid        = w_rsp_valid;
  assign bus.rsp_sel          = r_rsp_sel[r_rsp_rptr];
  assign bus.rsp_data         = r_rsp_data[r_rsp_rptr];
  assign bus.start            = w_start;
  assign bus.slaveSelect      = w_slave_select;
  assign bus.masterDataToSend = r_data;
  assign bus.busy             = w_busy;
  assign bus.err              = r_err;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer (DEPTH=4, XFER_CYCLES=9, GAP_CYCLES=2).
// The SPI master model returns the transmitted byte XOR 8'h99 (8'hA5 -> 8'h3C).
module tb_spi_xfer_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_xfer_sequencer_if bus ();

  assign bus.masterDataReceived = bus.masterDataToSend ^ 8'h99;

  spi_xfer_sequencer #(
    .DEPTH       (4),
    .XFER_CYCLES (9),
    .GAP_CYCLES  (2)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_start = 0;
  int ss_run = 0;
  int min_gap = 1000;
  logic [9:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock; observe at the following negedge and track start pulses and
  // the length of slaveSelect=3 runs preceding each new selection.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (bus.start === 1'b1) n_start++;
    if (bus.slaveSelect == 2'd3) begin
      ss_run++;
    end else begin
      if (ss_run > 0 && ss_run < min_gap) min_gap = ss_run;
      ss_run = 0;
    end
  endtask

  task automatic push_cmd(input logic [1:0] sel, input logic [7:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = sel;
    bus.cmd_data  = data;
    for (int i = 0; i < 200 && bus.cmd_ready !== 1'b1; i++) step();
    check_eq("push_ready", {31'd0, bus.cmd_ready}, 32'd1);
    step();
    bus.cmd_valid = 1'b0;
    if (sel != 2'd3) exp_q.push_back({sel, data ^ 8'h99});
  endtask

  task automatic pop_rsp(input string tag);
    logic [9:0] exp;
    for (int i = 0; i < 200 && bus.rsp_valid !== 1'b1; i++) step();
    check_eq({tag, "_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
    check_eq(tag, {22'd0, bus.rsp_sel, bus.rsp_data}, {22'd0, exp});
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_start"}, {31'd0, bus.start}, 32'd0);
    check_eq({tag, "_ss"}, {30'd0, bus.slaveSelect}, 32'd3);
    check_eq({tag, "_mdts"}, {24'd0, bus.masterDataToSend}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check_eq({tag, "_err"}, {31'd0, bus.err}, 32'd0);
    check_eq({tag, "_cmd_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
    check_eq({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    int n0;
    int start_at;
    int rsp_at;
    logic ss_ok;
    logic found;

    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_sel   = 2'd0;
    bus.cmd_data  = 8'd0;
    bus.rsp_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    step();
    step();

    // Single command sel=1, 8'hA5: launch latency and response {1, 8'h3C}
    n0 = n_start;
    start_at = 0;
    rsp_at = 0;
    ss_ok = 1'b1;
    push_cmd(2'd1, 8'hA5);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 1) begin
        check_eq("s1_setup_ss", {30'd0, bus.slaveSelect}, 32'd1);
        check_eq("s1_setup_mdts", {24'd0, bus.masterDataToSend}, 32'hA5);
        check_eq("s1_setup_start", {31'd0, bus.start}, 32'd0);
        check_eq("s1_setup_busy", {31'd0, bus.busy}, 32'd1);
      end
      if (bus.start === 1'b1 && start_at == 0) start_at = k;
      if (k <= 11 && bus.slaveSelect != 2'd1) ss_ok = 1'b0;
      if (bus.rsp_valid === 1'b1 && rsp_at == 0) rsp_at = k;
    end
    check_eq("s1_start_cycle", start_at, 2);
    check_eq("s1_start_count", n_start - n0, 1);
    check_eq("s1_ss_held", {31'd0, ss_ok}, 32'd1);
    check_eq("s1_rsp_latency", rsp_at, 13);
    check_eq("s1_rsp", {22'd0, bus.rsp_sel, bus.rsp_data}, {22'd0, 2'd1, 8'h3C});
    check_eq("s1_idle_ss", {30'd0, bus.slaveSelect}, 32'd3);
    check_eq("s1_idle_mdts", {24'd0, bus.masterDataToSend}, 32'hA5);
    check_eq("s1_idle_busy", {31'd0, bus.busy}, 32'd0);
    pop_rsp("s1_pop");

    // sel=3 is dropped with err; following sel=0, 8'h01 runs normally
    n0 = n_start;
    push_cmd(2'd3, 8'hEE);
    push_cmd(2'd0, 8'h01);
    for (int k = 0; k < 20; k++) step();
    check_eq("s4_err", {31'd0, bus.err}, 32'd1);
    check_eq("s4_start_count", n_start - n0, 1);
    check_eq("s4_rsp", {22'd0, bus.rsp_sel, bus.rsp_data}, {22'd0, 2'd0, 8'h98});
    pop_rsp("s4_pop");

    // Four commands, rsp_ready=0: response FIFO fills, gaps between launches
    n0 = n_start;
    min_gap = 1000;
    push_cmd(2'd0, 8'h10);
    push_cmd(2'd1, 8'h20);
    push_cmd(2'd2, 8'h30);
    push_cmd(2'd0, 8'h40);
    for (int k = 0; k < 70; k++) step();
    check_eq("s3_start_count", n_start - n0, 4);
    check_eq("s3_gap_ge2", {31'd0, min_gap >= 2}, 32'd1);
    check_eq("s3_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("s3_head", {22'd0, bus.rsp_sel, bus.rsp_data}, {22'd0, 2'd0, 8'h89});
    check_eq("err_sticky", {31'd0, bus.err}, 32'd1);

    // Simultaneous push/pop at DEPTH-1 on both FIFOs, order across pointer wrap
    n0 = n_start;
    push_cmd(2'd1, 8'h61);
    push_cmd(2'd2, 8'h62);
    push_cmd(2'd0, 8'h63);
    for (int k = 0; k < 3; k++) step();
    check_eq("s3_no_fifth_launch", n_start - n0, 0);
    pop_rsp("s6_pop0");
    push_cmd(2'd2, 8'h64);  // same edge as the FSM pops 8'h61
    check_eq("s6_cmd_occ", {31'd0, bus.cmd_ready}, 32'd1);
    check_eq("s6_launch_busy", {31'd0, bus.busy}, 32'd1);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (bus.slaveSelect == 2'd3 && bus.busy === 1'b1) found = 1'b1;
      else step();
    end
    check_eq("s6_capture_seen", {31'd0, found}, 32'd1);
    pop_rsp("s6_pop1");     // pops while CAPTURE pushes
    check_eq("s6_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    for (int k = 0; k < 20; k++) step();
    check_eq("s6_rsp_occ", n_start - n0, 2);
    check_eq("s6_busy", {31'd0, bus.busy}, 32'd0);
    push_cmd(2'd1, 8'h65);
    push_cmd(2'd2, 8'h66);
    check_eq("s6_cmd_full", {31'd0, bus.cmd_ready}, 32'd0);
    for (int i = 0; i < 8; i++) pop_rsp("s6_drain");
    for (int k = 0; k < 5; k++) step();
    check_eq("s6_empty", {31'd0, bus.rsp_valid}, 32'd0);

    // Five back-to-back commands with no launch possible (response FIFO full)
    push_cmd(2'd1, 8'h71);
    push_cmd(2'd2, 8'h72);
    push_cmd(2'd0, 8'h73);
    push_cmd(2'd1, 8'h74);
    for (int k = 0; k < 70; k++) step();
    n0 = n_start;
    push_cmd(2'd2, 8'h81);
    push_cmd(2'd0, 8'h82);
    push_cmd(2'd1, 8'h83);
    push_cmd(2'd2, 8'h84);
    check_eq("s2_full", {31'd0, bus.cmd_ready}, 32'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = 2'd0;
    bus.cmd_data  = 8'h85;
    for (int k = 0; k < 5; k++) step();
    check_eq("s2_held", {31'd0, bus.cmd_ready}, 32'd0);
    check_eq("s2_no_launch", n_start - n0, 0);
    pop_rsp("s2_pop0");
    push_cmd(2'd0, 8'h85);
    for (int i = 0; i < 8; i++) pop_rsp("s2_drain");

    // Reset during XFER: immediate reset outputs, no response, then normal operation
    for (int k = 0; k < 5; k++) step();
    n0 = n_start;
    push_cmd(2'd2, 8'h5A);
    for (int i = 0; i < 10 && n_start == n0; i++) step();
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("s5_rst");
    step();
    reset = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 20; k++) step();
    check_eq("s5_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    check_eq("s5_idle", {31'd0, bus.busy}, 32'd0);
    n0 = n_start;
    push_cmd(2'd0, 8'hC3);
    for (int k = 0; k < 20; k++) step();
    check_eq("s5_start_count", n_start - n0, 1);
    check_eq("s5_rsp", {22'd0, bus.rsp_sel, bus.rsp_data}, {22'd0, 2'd0, 8'h5A});
    pop_rsp("s5_pop");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/spi_xfer_sequencer.md
SPI_XFER_SEQUENCER -- requirements
Module: spi_xfer_sequencer

Interface
Parameters:
REQ-001 The block SHALL have parameter DEPTH, default 4: entries in each of the command and response FIFOs (power of two, 2..16).
REQ-002 The block SHALL have parameter XFER_CYCLES, default 9: clk cycles waited after the start pulse before capturing received data.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 2: idle clk cycles with slaveSelect=3 between transfers.

Ports (name  direction  width  meaning):
REQ-004 The block SHALL have the following ports:
  clk  in  1  sole clock; all state on posedge.
  reset  in  1  asynchronous, active-high.
  cmd_valid  in  1  command offered.
  cmd_ready  out  1  command FIFO not full.
  cmd_sel  in  2  target slave 0..2.
  cmd_data  in  8  byte to transmit.
  rsp_valid  out  1  response FIFO not empty.
  rsp_ready  in  1  consumer accepts the head response.
  rsp_sel  out  2  slave of the head response.
  rsp_data  out  8  byte received from that slave.
  start  out  1  one-cycle launch pulse to the SPI master.
  slaveSelect  out  2  slave select to the SPI master; 3 = none.
  masterDataToSend  out  8  byte for the SPI master to transmit.
  masterDataReceived  in  8  byte shifted in by the SPI master.
  busy  out  1  FSM is not in IDLE.
  err  out  1  sticky: a command with cmd_sel=3 was received.

Function
REQ-005 A command SHALL be pushed on a posedge when cmd_valid=1 and cmd_ready=1; cmd_ready SHALL be 0 exactly when the command FIFO holds DEPTH entries.
REQ-006 A response SHALL be popped on a posedge when rsp_valid=1 and rsp_ready=1; rsp_sel and rsp_data SHALL show the head entry whenever rsp_valid=1.
REQ-007 Both FIFOs SHALL accept a push and a pop in the same cycle when not full; pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with a counter of width clog2(DEPTH)+1.
REQ-008 The FSM SHALL have the states IDLE, SETUP, START, XFER, CAPTURE and GAP.
REQ-009 In IDLE, the FSM SHALL move to SETUP when the command FIFO is non-empty and the response FIFO is not full, popping the head command into registers sel_q and data_q on that edge.
REQ-010 If the popped command has sel=3, the FSM SHALL set err, discard the command, and stay in IDLE (no SETUP, no start pulse).
REQ-011 SETUP SHALL last 1 cycle with slaveSelect=sel_q, masterDataToSend=data_q and start=0.
REQ-012 START SHALL last 1 cycle with start=1, while slaveSelect and masterDataToSend hold their values.
REQ-013 XFER SHALL last exactly XFER_CYCLES cycles, counted by a down-counter, with start=0 and the outputs held.
REQ-014 In CAPTURE (1 cycle), the block SHALL push {sel_q, masterDataReceived} into the response FIFO; space is guaranteed by REQ-009.
REQ-015 In GAP, the block SHALL drive slaveSelect=3 for GAP_CYCLES cycles, then return to IDLE.
REQ-016 Launch latency SHALL be fixed: with both FIFOs empty, a command pushed at edge N SHALL produce start=1 in cycle N+3 and rsp_valid=1 after edge N+4+XFER_CYCLES.
REQ-017 Only one transfer SHALL be in flight at a time; response order SHALL equal command order.
REQ-018 Outside SETUP, START and XFER, slaveSelect SHALL be 3 and masterDataToSend SHALL hold its last value.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 err SHALL stay 1 until reset.

Reset
REQ-021 While reset=1, asynchronously and regardless of clk: the FSM SHALL be IDLE, both FIFOs empty, start=0, slaveSelect=3, masterDataToSend=0, busy=0, err=0, cmd_ready=1, rsp_valid=0.
REQ-022 Reset asserted mid-transfer SHALL abort that transfer with no response pushed; after deassertion, the first posedge SHALL operate from the reset state.

Verification
REQ-023 The bench SHALL cover each of the following directed scenarios:
  - Single command sel=1, data=8'hA5, model returns 8'h3C -> one start pulse, slaveSelect=1 during SETUP/START/XFER, response {1, 8'h3C}, latency per REQ-016.
  - Push 5 commands back-to-back with DEPTH=4 and no launch possible -> cmd_ready=0 after the 4th; 5th is held until a pop.
  - Four commands with rsp_ready=0 -> four responses fill the FIFO; no fifth launch; each start pulse separated by a slaveSelect=3 GAP of at least 2 cycles.
  - Command sel=3 followed by sel=0, data=8'h01 -> err=1, no start pulse for the first, normal transfer for the second.
  - Reset pulse during XFER -> outputs immediately at reset values; no response; a later command works normally.
  - Simultaneous push and pop on the response and command FIFOs at DEPTH-1 occupancy -> occupancy unchanged, data order preserved across pointer wrap.
